// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
// Fixed-latency storage with byte/half/word access and fault flagging.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEMREAD,
    input  logic        MEMWRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        ERROR
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_rd;
    logic                    r_wr;
    logic [2:0]              r_f3;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic                    r_error;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_req;
    logic                    w_accept;
    logic                    w_commit;
    logic                    w_rd;
    logic                    w_wr;
    logic [2:0]              w_f3;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [31:0]             w_wdata;
    logic [ADDR_WIDTH-3:0]   w_idx;
    logic [31:0]             w_word;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load;
    logic [31:0]             w_wword;
    logic [3:0]              w_wmask;
    logic                    w_fault;
    logic                    w_unused;

    // Upper address bits alias onto the decoded range.
    assign w_unused = ^ADDRESS[31:ADDR_WIDTH];

    assign w_req    = MEMREAD | MEMWRITE;
    assign w_accept = (r_state == S_IDLE) && w_req;

    // Single-cycle latency commits on the accept edge using live inputs.
    assign w_commit = (w_accept && (LATENCY == 1)) ||
                      ((r_state == S_BUSY) && (r_cnt == 4'd1));

    assign w_rd    = w_accept ? MEMREAD : r_rd;
    assign w_wr    = w_accept ? MEMWRITE : r_wr;
    assign w_f3    = w_accept ? FUNCT3 : r_f3;
    assign w_addr  = w_accept ? ADDRESS[ADDR_WIDTH-1:0] : r_addr;
    assign w_wdata = w_accept ? WRITEDATA : r_wdata;
    assign w_idx   = w_addr[ADDR_WIDTH-1:2];
    assign w_word  = r_mem[w_idx];

    assign BUSYWAIT = !RESET &&
                      (w_accept || (r_state == S_BUSY));
    assign READDATA = r_rdata;
    assign ERROR    = r_error;

    // Fault classification of the committing access.
    always_comb begin
        w_fault = 1'b0;
        if (w_rd && w_wr)
            w_fault = 1'b1;
        if ((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111))
            w_fault = 1'b1;
        if (w_wr && w_f3[2])
            w_fault = 1'b1;
        if ((w_f3[1:0] == 2'b01) && w_addr[0])
            w_fault = 1'b1;
        if ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00))
            w_fault = 1'b1;
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        w_byte = 8'h00;
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load = w_word;
        case (w_addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        case (w_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store lane mask and replicated write data.
    always_comb begin
        w_wword = w_wdata;
        w_wmask = 4'b1111;
        case (w_f3[1:0])
            2'b00: begin
                w_wword = {4{w_wdata[7:0]}};
                w_wmask = 4'b0001 << w_addr[1:0];
            end
            2'b01: begin
                w_wword = {2{w_wdata[15:0]}};
                w_wmask = w_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wword = w_wdata;
                w_wmask = 4'b1111;
            end
        endcase
    end

    // Storage: cleared on reset, written only by a clean store commit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= 32'h0;
        end else if (w_commit && w_wr && !w_fault) begin
            for (int b = 0; b < 4; b++)
                if (w_wmask[b])
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
    end

    // Request FSM with latched request and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_rd    <= MEMREAD;
                        r_wr    <= MEMWRITE;
                        r_f3    <= FUNCT3;
                        r_addr  <= ADDRESS[ADDR_WIDTH-1:0];
                        r_wdata <= WRITEDATA;
                        r_cnt   <= LAT_M1;
                        r_state <= (LATENCY == 1) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_error <= 1'b0;
                end
            endcase
            if (w_commit) begin
                r_error <= w_fault;
                if (w_rd)
                    r_rdata <= w_fault ? 32'h0 : w_load;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder.
// Compares against a byte-level memory model.
module tb_dmem_responder;

    localparam int AW  = 10;
    localparam int LAT = 4;
    localparam int NW  = 1 << (AW - 2);

    logic        CLK;
    logic        RESET;
    logic        MEMREAD;
    logic        MEMWRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        ERROR;

    int n_chk;
    int n_pass;

    logic [31:0] m_mem [0:NW-1];
    logic [31:0] m_rdata;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .MEMREAD(MEMREAD),
        .MEMWRITE(MEMWRITE),
        .FUNCT3(FUNCT3),
        .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT),
        .ERROR(ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NW; i++)
            m_mem[i] = 32'h0;
        m_rdata = 32'h0;
    endfunction

    // Reference: plain byte arithmetic on a word array.
    function automatic void model(input logic rd, input logic wr,
                                  input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic [31:0] d,
                                  output logic err);
        int ba, w, off, nb;
        logic [31:0] v;
        ba  = int'(a % 32'(1 << AW));
        w   = ba / 4;
        off = ba % 4;
        nb  = 1 << f3[1:0];
        err = (rd && wr) || (f3 == 3) || (f3 == 6) || (f3 == 7)
              || (wr && f3[2]) || (nb == 2 && off % 2 != 0)
              || (nb == 4 && off != 0);
        if (rd) begin
            if (err) begin
                m_rdata = 32'h0;
            end else begin
                v = m_mem[w] >> (8 * off);
                if (nb == 1) begin
                    v = v & 32'hFF;
                    if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
                end else if (nb == 2) begin
                    v = v & 32'hFFFF;
                    if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
                end
                m_rdata = v;
            end
        end else if (!err) begin
            for (int k = 0; k < nb; k++)
                m_mem[w][8*(off+k) +: 8] = d[8*k +: 8];
        end
    endfunction

    task automatic access(input logic rd, input logic wr,
                          input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got_rd,
                          output logic got_err);
        int n;
        logic exp_err;
        model(rd, wr, f3, a, d, exp_err);
        @(negedge CLK);
        MEMREAD   = rd;
        MEMWRITE  = wr;
        FUNCT3    = f3;
        ADDRESS   = a;
        WRITEDATA = d;
        #1;
        n = 0;
        while (BUSYWAIT === 1'b1 && n < 20) begin
            n++;
            @(negedge CLK);
            MEMREAD   = 1'($urandom);
            MEMWRITE  = 1'($urandom);
            FUNCT3    = 3'($urandom);
            ADDRESS   = $urandom;
            WRITEDATA = $urandom;
            #1;
        end
        chk("busy_cycles", 32'(n), 32'(LAT));
        chk("done_err", {31'h0, ERROR}, {31'h0, exp_err});
        chk("done_rdata", READDATA, m_rdata);
        got_rd  = READDATA;
        got_err = ERROR;
        MEMREAD  = 1'b0;
        MEMWRITE = 1'b0;
        @(negedge CLK);
        #1;
        chk("idle_err", {31'h0, ERROR}, 32'h0);
        chk("idle_busy", {31'h0, BUSYWAIT}, 32'h0);
    endtask

    logic [31:0] r;
    logic        e;
    logic [2:0]  rf3;
    logic [31:0] ra;
    int          kind;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        RESET     = 1'b1;
        MEMREAD   = 1'b0;
        MEMWRITE  = 1'b0;
        FUNCT3    = 3'd0;
        ADDRESS   = 32'h0;
        WRITEDATA = 32'h0;
        model_clear();
        repeat (2) @(negedge CLK);
        MEMREAD = 1'b1;
        #1;
        chk("busy_in_reset", {31'h0, BUSYWAIT}, 32'h0);
        MEMREAD = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk("rst_rdata", READDATA, 32'h0);
        chk("rst_err", {31'h0, ERROR}, 32'h0);

        access(1, 0, 3'b010, 32'h0, 0, r, e);
        chk("lw0", r, 32'h0);
        access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, r, e);
        access(1, 0, 3'b010, 32'h10, 0, r, e);
        chk("lw10", r, 32'hDEADBEEF);
        access(0, 1, 3'b000, 32'h11, 32'h80, r, e);
        access(1, 0, 3'b000, 32'h11, 0, r, e);
        chk("lb11", r, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h11, 0, r, e);
        chk("lbu11", r, 32'h00000080);
        access(1, 0, 3'b010, 32'h10, 0, r, e);
        chk("lw10b", r, 32'hDEAD80EF);
        access(1, 0, 3'b001, 32'h12, 0, r, e);
        chk("lh12", r, 32'hFFFFDEAD);
        access(1, 0, 3'b001, 32'h13, 0, r, e);
        chk("lh13_err", {31'h0, e}, 32'h1);
        chk("lh13_rd", r, 32'h0);
        access(0, 1, 3'b010, 32'h22, 32'h12345678, r, e);
        chk("sw22_err", {31'h0, e}, 32'h1);
        access(1, 0, 3'b010, 32'h20, 0, r, e);
        chk("lw20", r, 32'h0);
        access(0, 1, 3'b010, 32'h404, 32'hA5A5A5A5, r, e);
        access(1, 0, 3'b010, 32'h004, 0, r, e);
        chk("alias", r, 32'hA5A5A5A5);
        access(1, 1, 3'b010, 32'h24, 32'h55, r, e);
        chk("both_err", {31'h0, e}, 32'h1);
        access(1, 0, 3'b010, 32'h24, 0, r, e);
        chk("both_nowr", r, 32'h0);

        // Reset during the second busy cycle of a store.
        @(negedge CLK);
        MEMWRITE  = 1'b1;
        FUNCT3    = 3'b010;
        ADDRESS   = 32'h30;
        WRITEDATA = 32'h1;
        @(negedge CLK);
        MEMWRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        model_clear();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("abort_busy", {31'h0, BUSYWAIT}, 32'h0);
        chk("abort_rdata", READDATA, 32'h0);
        access(1, 0, 3'b010, 32'h30, 0, r, e);
        chk("lw30", r, 32'h0);
        access(1, 0, 3'b010, 32'h10, 0, r, e);
        chk("cleared", r, 32'h0);

        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            rf3  = 3'($urandom);
            ra   = 32'($urandom_range(0, 63))
                   | ($urandom & 32'hFFFFFC00);
            if (kind < 5)
                access(1, 0, rf3, ra, 0, r, e);
            else if (kind < 9)
                access(0, 1, rf3, ra, $urandom, r, e);
            else
                access(1, 1, rf3, ra, $urandom, r, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
